branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, number of 2-bit counters; legal values are powers of two from 4 to 1024.
REQ-002 SHALL provide parameter XLEN, default 32, PC width.
REQ-003 SHALL derive localparam IDXW = log2(ENTRIES).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 branch_D  in  1  conditional branch in Decode (op 1100011).
REQ-007 jump_D  in  1  JAL in Decode (op 1101111).
REQ-008 pc_D  in  XLEN  PC of the Decode instruction.
REQ-009 branch_E  in  1  valid conditional branch in Execute.
REQ-010 funct3_E  in  3  branch type in Execute.
REQ-011 N, Z  in  1 each  ALU flags for the Execute compare.
REQ-012 pc_E  in  XLEN  PC of the Execute branch.
REQ-013 predicted_taken_E  in  1  predict_taken_D pipelined to Execute by the core.
REQ-014 predict_taken_D  out  1  Decode prediction.
REQ-015 condition_met_E  out  1  resolved branch outcome.
REQ-016 mispredict_E  out  1  prediction disagreed with outcome.
REQ-017 PCSrcE  out  2  00 PC+4, 01 Decode target, 10 recover to pc_E+4, 11 recover to Execute branch target.
REQ-018 branch_count, mispredict_count  out  32 each  statistics (see Configuration).

Function
REQ-019 SHALL hold ENTRIES 2-bit saturating counters, indexed by pc[IDXW+1:2]; values 00 SN, 01 WN, 10 WT, 11 ST.
REQ-020 predict_taken_D SHALL be combinational: 1 if jump_D, else counter[idx(pc_D)][1] if branch_D, else 0.
REQ-021 condition_met_E SHALL be Z for funct3 000, !Z for 001, N for 100, !N for 101, and 0 for all other funct3 or when branch_E=0.
REQ-022 mispredict_E SHALL be branch_E & supported funct3 & (condition_met_E != predicted_taken_E).
REQ-023 PCSrcE priority: mispredict_E with condition_met_E=0 -> 10; mispredict_E with condition_met_E=1 -> 11; else predict_taken_D -> 01; else 00.
REQ-024 On a clock edge with branch_E=1 and supported funct3, counter[idx(pc_E)] SHALL increment if taken and decrement otherwise, saturating at 11 and 00.
REQ-025 Unsupported funct3 (010, 011, 110, 111) SHALL NOT update any counter and SHALL NOT assert mispredict_E.
REQ-026 jump_D SHALL NOT read or write the table.
REQ-027 When the same index is read in Decode and written in Execute in one cycle, the Decode read SHALL return the pre-update value; the update becomes visible the next cycle.
REQ-028 branch_D and jump_D asserted together is illegal input; jump_D SHALL take precedence.
REQ-029 Update latency SHALL be one cycle; outputs other than counters and statistics SHALL have no internal state.

Reset
REQ-030 rst_n low SHALL asynchronously set every counter to 10 (WT), preserving predict-taken behaviour after reset.
REQ-031 rst_n low SHALL clear branch_count and mispredict_count to 0.
REQ-032 An update coinciding with reset assertion SHALL be discarded; release SHALL be synchronised by the core's reset logic.

Configuration
REQ-033 Macro BP_STATS_EN defined: branch_count SHALL increment on each REQ-024 update and mispredict_count on each mispredict_E cycle; both wrap modulo 2^32.
REQ-034 BP_STATS_EN undefined: both counters SHALL be omitted and the outputs tied to 0.

Verification
REQ-035 After reset, pc_D=0x40, branch_D=1 -> predict_taken_D=1, PCSrcE=01.
REQ-036 Two not-taken resolves on pc_E=0x40 (funct3 000, Z=0) -> counter 00; next branch_D at pc_D=0x40 -> predict_taken_D=0.
REQ-037 branch_E=1, funct3 100, N=0, predicted_taken_E=1 -> condition_met_E=0, mispredict_E=1, PCSrcE=10, even with jump_D=1.
REQ-038 ENTRIES=16: update pc_E=0x04 and read pc_D=0x44 in the same cycle -> old value read; new value visible next cycle (aliasing).
REQ-039 Five taken resolves on one index -> counter saturates at 11; funct3 010 resolve -> no change, mispredict_E=0.
REQ-040 With BP_STATS_EN: 3 resolves, 1 mispredict -> branch_count=3, mispredict_count=1; rst_n pulse mid-stream -> both 0 and all counters 10.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal predictor built from a table of 2-bit saturating
// counters indexed by pc[IDXW+1:2].
// Decode looks up a prediction combinationally. Execute resolves the branch,
// flags a mispredict, selects the next-PC source and trains the counter.
// Optional build macro BP_STATS_EN adds branch and mispredict statistics
// counters. Without it, those outputs are tied to zero.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_D,
  input  logic            jump_D,
  input  logic [XLEN-1:0] pc_D,
  input  logic            branch_E,
  input  logic [2:0]      funct3_E,
  input  logic            N,
  input  logic            Z,
  input  logic [XLEN-1:0] pc_E,
  input  logic            predicted_taken_E,
  output logic            predict_taken_D,
  output logic            condition_met_E,
  output logic            mispredict_E,
  output logic [1:0]      PCSrcE,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDXW = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef enum logic [1:0] {
    SRC_PC4     = 2'b00,
    SRC_DEC_TGT = 2'b01,
    SRC_REC_PC4 = 2'b10,
    SRC_REC_TGT = 2'b11
  } pc_src_t;

  ctr_t            table_q [ENTRIES];
  logic [IDXW-1:0] idx_d;
  logic [IDXW-1:0] idx_e;
  logic            supported;
  logic            update;
  pc_src_t         pc_src;

  // Word-aligned PCs: drop the two byte-offset bits, keep IDXW index bits.
  assign idx_d = pc_D[IDXW+1:2];
  assign idx_e = pc_E[IDXW+1:2];

  // PC bits outside the index field do not take part in the lookup.
  logic pc_bits_unused;
  assign pc_bits_unused = ^{pc_D[XLEN-1:IDXW+2], pc_D[1:0],
                            pc_E[XLEN-1:IDXW+2], pc_E[1:0]};

  // Decode lookup. A jump is always taken and must not touch the table.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    predict_taken_D = 1'b0;
    if (jump_D)
      predict_taken_D = 1'b1;
    else if (branch_D)
      predict_taken_D = table_q[idx_d][1];
  end

  // Execute resolution: evaluate the branch condition for the supported compares.
  always_comb begin
    supported       = 1'b0;
    condition_met_E = 1'b0;
    if (branch_E) begin
      unique case (funct3_E)
        3'b000:  begin supported = 1'b1; condition_met_E =  Z; end
        3'b001:  begin supported = 1'b1; condition_met_E = ~Z; end
        3'b100:  begin supported = 1'b1; condition_met_E =  N; end
        3'b101:  begin supported = 1'b1; condition_met_E = ~N; end
        default: begin supported = 1'b0; condition_met_E = 1'b0; end
      endcase
    end
  end

  assign update       = branch_E & supported;
  assign mispredict_E = update & (condition_met_E != predicted_taken_E);

  // Next-PC select. A recovery in Execute overrides any Decode redirect.
  always_comb begin
    pc_src = SRC_PC4;
    if (mispredict_E)
      pc_src = condition_met_E ? SRC_REC_TGT : SRC_REC_PC4;
    else if (predict_taken_D)
      pc_src = SRC_DEC_TGT;
  end

  assign PCSrcE = pc_src;

  // Counter training. Reset restores weakly-taken so the core keeps
  // predicting taken. The Decode read in the same cycle sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this table is a flop array, not a RAM macro, so it can be reset
    // like any other register; state updates use <= so that same-cycle
    // readers see the old value.
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        table_q[i] <= WEAK_T;
    end else if (update) begin
      if (condition_met_E) begin
        if (table_q[idx_e] != STRONG_T)
          table_q[idx_e] <= ctr_t'(table_q[idx_e] + 2'b01);
      end else begin
        if (table_q[idx_e] != STRONG_NT)
          table_q[idx_e] <= ctr_t'(table_q[idx_e] - 2'b01);
      end
    end
  end

`ifdef BP_STATS_EN
  // Statistics: count trained branches and mispredicts, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update)
        branch_count <= branch_count + 32'd1;
      if (mispredict_E)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations for
// branch_predictor (ENTRIES=16, XLEN=32). The statistics expectations follow
// the BP_STATS_EN build macro.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_D, jump_D;
  logic [31:0] pc_D;
  logic        branch_E;
  logic [2:0]  funct3_E;
  logic        N, Z;
  logic [31:0] pc_E;
  logic        predicted_taken_E;
  logic        predict_taken_D, condition_met_E, mispredict_E;
  logic [1:0]  PCSrcE;
  logic [31:0] branch_count, mispredict_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_branches = 0;
  int exp_mispreds = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_D(branch_D), .jump_D(jump_D), .pc_D(pc_D),
    .branch_E(branch_E), .funct3_E(funct3_E), .N(N), .Z(Z), .pc_E(pc_E),
    .predicted_taken_E(predicted_taken_E),
    .predict_taken_D(predict_taken_D), .condition_met_E(condition_met_E),
    .mispredict_E(mispredict_E), .PCSrcE(PCSrcE),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    branch_D = 0; jump_D = 0; pc_D = '0;
    branch_E = 0; funct3_E = '0; N = 0; Z = 0; pc_E = '0; predicted_taken_E = 0;
  endtask

  // Look up a branch in Decode with Execute idle.
  task automatic decode_check(input string tag, input logic [31:0] pc, input logic exp_pred);
    branch_E = 0; jump_D = 0; branch_D = 1; pc_D = pc;
    #1;
    check(tag, {31'd0, predict_taken_D}, {31'd0, exp_pred});
    branch_D = 0;
  endtask

  // Present one Execute branch, check the combinational outputs, then clock it.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                         input logic n, input logic z, input logic pred,
                         input logic exp_cond, input logic exp_mis, input logic [1:0] exp_src);
    branch_E = 1; pc_E = pc; funct3_E = f3; N = n; Z = z; predicted_taken_E = pred;
    #1;
    check({tag, ".cond"}, {31'd0, condition_met_E}, {31'd0, exp_cond});
    check({tag, ".mis"},  {31'd0, mispredict_E},    {31'd0, exp_mis});
    check({tag, ".src"},  {30'd0, PCSrcE},          {30'd0, exp_src});
    if (f3 inside {3'b000, 3'b001, 3'b100, 3'b101}) exp_branches++;
    if (exp_mis) exp_mispreds++;
    @(posedge clk); #1;
    branch_E = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef BP_STATS_EN
    check({tag, ".branches"}, branch_count,     exp_branches);
    check({tag, ".mispreds"}, mispredict_count, exp_mispreds);
`else
    check({tag, ".branches"}, branch_count,     32'd0);
    check({tag, ".mispreds"}, mispredict_count, 32'd0);
`endif
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    // Table is weakly taken while still in reset.
    decode_check("rst_hold_pred", 32'h40, 1'b1);
    check_stats("rst");
    rst_n = 1;
    @(posedge clk); #1;

    // After reset: predict taken and redirect from Decode.
    branch_D = 1; pc_D = 32'h40; #1;
    check("after_rst.pred", {31'd0, predict_taken_D}, 32'd1);
    check("after_rst.src",  {30'd0, PCSrcE},          32'd1);
    branch_D = 0;

    // Two not-taken resolves at 0x40: WT -> WN -> SN.
    resolve("nt1", 32'h40, 3'b000, 0, 0, 1, 0, 1, 2'b10);
    // Same-index Decode read during second update sees WN (predict 0).
    branch_D = 1; pc_D = 32'h40;
    resolve("nt2", 32'h40, 3'b000, 0, 0, 0, 0, 0, 2'b00);
    branch_D = 0;
    decode_check("after_nt2", 32'h40, 1'b0);

    // BLT not taken, predicted taken: recovery beats the jump in Decode.
    jump_D = 1; branch_D = 1; pc_D = 32'h40;
    resolve("blt_rec", 32'h80, 3'b100, 0, 0, 1, 0, 1, 2'b10);
    // Index 0 already SN: the not-taken update saturates at the floor.
    decode_check("floor_sat", 32'h40, 1'b0);

    // Jump beats a branch on an SN entry.
    jump_D = 1; branch_D = 1; pc_D = 32'h40; #1;
    check("jump_prec.pred", {31'd0, predict_taken_D}, 32'd1);
    jump_D = 0; branch_D = 0;

    // BGE taken, predicted taken: no recovery, nothing in Decode.
    resolve("bge_ok", 32'h10, 3'b101, 0, 0, 1, 1, 0, 2'b00);
    // BNE taken, predicted not taken: recover to the target.
    resolve("bne_rec", 32'h20, 3'b001, 0, 0, 0, 1, 1, 2'b11);
    check_stats("mid");

    // Aliasing: update index 1 via 0x04 while reading 0x44.
    branch_D = 1; pc_D = 32'h44;
    branch_E = 1; pc_E = 32'h04; funct3_E = 3'b000; Z = 0; predicted_taken_E = 1;
    #1;
    check("alias.old", {31'd0, predict_taken_D}, 32'd1);
    exp_branches++; exp_mispreds++;
    @(posedge clk); #1;
    branch_E = 0;
    check("alias.new", {31'd0, predict_taken_D}, 32'd0);
    branch_D = 0;

    // Five taken resolves at 0x08 saturate at ST.
    for (int i = 0; i < 5; i++)
      resolve("sat_t", 32'h08, 3'b000, 0, 1, 1, 1, 0, 2'b00);
    decode_check("sat.pred", 32'h08, 1'b1);
    // Unsupported funct3 010: no outcome, no mispredict, no update.
    resolve("f3_010", 32'h08, 3'b010, 1, 1, 1, 0, 0, 2'b00);
    resolve("f3_110", 32'h08, 3'b110, 1, 0, 0, 0, 0, 2'b00);
    // ST -> WT still taken, then WT -> WN.
    resolve("dec1", 32'h08, 3'b001, 0, 1, 1, 0, 1, 2'b10);
    decode_check("dec1.pred", 32'h08, 1'b1);
    resolve("dec2", 32'h08, 3'b001, 0, 1, 1, 0, 1, 2'b10);
    decode_check("dec2.pred", 32'h08, 1'b0);
    check_stats("pre_rst");

    // Reset pulse mid-stream, overlapping a pending update.
    branch_E = 1; pc_E = 32'h08; funct3_E = 3'b000; Z = 0; predicted_taken_E = 1;
    #2 rst_n = 0;
    #1;
    branch_E = 0;
    exp_branches = 0; exp_mispreds = 0;
    check_stats("rst_pulse");
    decode_check("rst_pulse.idx0", 32'h40, 1'b1);
    decode_check("rst_pulse.idx2", 32'h08, 1'b1);
    decode_check("rst_pulse.idx1", 32'h44, 1'b1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    decode_check("rst_rel.idx2", 32'h08, 1'b1);

    // Three resolves with one mispredict.
    resolve("post1", 32'h0C, 3'b000, 0, 1, 1, 1, 0, 2'b00);
    resolve("post2", 32'h0C, 3'b100, 1, 0, 1, 1, 0, 2'b00);
    resolve("post3", 32'h0C, 3'b101, 1, 0, 1, 0, 1, 2'b10);
    check_stats("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
